multicycle_controller: RTL

//  Parametrised multi-cycle successor to the single-cycle control path. An FSM sequences

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback over one memory port, NZCV flags, retire count.
// Each instruction takes 2-5 states plus memory wait cycles; mem_req is held until mem_ready or the timeout fault.
module multicycle_controller #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16,
  parameter int MEM_TO  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [3:0]         alu_flags,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               imm_src,
  output logic               mem_to_reg,
  output logic [3:0]         alu_control,
  output logic [3:0]         flags,
  output logic [CNT_W-1:0]   retired,
  output logic               fault
);

  localparam int TW = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
  localparam logic [TW-1:0] TO_V = TW'(MEM_TO);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        flags_q, smp_q;
  logic [CNT_W-1:0]  retired_q;
  logic              fault_q;
  logic [TW-1:0]     timer_q;

  logic [3:0] cond, funct;
  logic [1:0] op;
  logic       sbit;
  assign cond  = instr[INSTR_W-1 -: 4];
  assign op    = instr[INSTR_W-5 -: 2];
  assign funct = instr[INSTR_W-7 -: 4];
  assign sbit  = instr[INSTR_W-11];

  generate
    if (INSTR_W > 11) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^instr[INSTR_W-12:0];
    end
  endgenerate

  logic n_f, z_f, c_f, v_f, cond_pass;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = !z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = !c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = !n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = !v_f;
      4'h8: cond_pass = c_f && !z_f;
      4'h9: cond_pass = !c_f || z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = !z_f && (n_f == v_f);
      4'hD: cond_pass = z_f || (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // A transfer on the cycle the timer reaches MEM_TO still wins over the fault.
  logic time_up;
  assign time_up = (MEM_TO != 0) && (timer_q == TO_V);

  logic req, we, irw, pcw, pcs, rw, imm, mtr, retire, set_flags;
  logic [3:0] aluc;

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    we        = 1'b0;
    irw       = 1'b0;
    pcw       = 1'b0;
    pcs       = 1'b0;
    rw        = 1'b0;
    imm       = 1'b0;
    mtr       = 1'b0;
    aluc      = 4'h0;
    retire    = 1'b0;
    set_flags = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end else if (time_up) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (!cond_pass) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          case (op)
            2'b10:   state_d = S_ADDR;
            2'b11:   state_d = S_BRANCH;
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        aluc    = funct;
        imm     = op[0];
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw        = (funct != 4'hA);
        set_flags = sbit;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        imm     = 1'b1;
        state_d = sbit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (time_up) state_d = S_FAULT;
      end
      S_MEMWB: begin
        rw      = 1'b1;
        mtr     = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        req = 1'b1;
        we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (time_up) begin
          state_d = S_FAULT;
        end
      end
      S_BRANCH: begin
        pcw     = 1'b1;
        pcs     = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'h0;
      smp_q     <= 4'h0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)    timer_q <= '0;
      else if (req && !mem_ready) timer_q <= timer_q + TW'(1);
      if (state_q == S_EXEC)     smp_q <= alu_flags;
      if (set_flags)             flags_q <= smp_q;
      if (retire)                retired_q <= retired_q + CNT_W'(1);
      if (state_d == S_FAULT)    fault_q <= 1'b1;
    end
  end

  // Gating with reset drops the strobes the moment reset asserts, not at the next edge.
  assign mem_req     = reset & req;
  assign mem_we      = reset & we;
  assign ir_write    = reset & irw;
  assign pc_write    = reset & pcw;
  assign pc_src      = reset & pcs;
  assign reg_write   = reset & rw;
  assign imm_src     = reset & imm;
  assign mem_to_reg  = reset & mtr;
  assign alu_control = reset ? aluc : 4'h0;
  assign flags       = flags_q;
  assign retired     = retired_q;
  assign fault       = fault_q;

endmodule
